// File: rtl/mcash_xbar_pkg.sv
// Shared defaults and types for the mcash cross bar request arbiter.
package mcash_xbar_pkg;

  localparam int MCASH_CH_NUM = 4;
  localparam int MCASH_ADDR_W = 32;
  localparam int MCASH_DATA_W = 64;
  localparam int MCASH_OP_W   = 3;

  // Requests are forwarded cache-line aligned; this many low address bits are cleared.
  localparam int LINE_OFF_W = 4;

  typedef logic [$clog2(MCASH_CH_NUM)-1:0] ch_id_t;

  typedef struct packed {
    logic [MCASH_OP_W-1:0]   op;
    logic [MCASH_ADDR_W-1:0] addr;
    logic [MCASH_DATA_W-1:0] data;
  } mcash_req_t;

endpackage

// File: rtl/mcash_rr_arbiter.sv
// Round-robin one-hot grant over N requesters; the search starts at rr_ptr and
// wraps upward, and the pointer moves past the winner only when advance is high.
module mcash_rr_arbiter #(
  parameter int N = 4,
  localparam int ID_W = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic            advance,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] grant_id
);

  logic [ID_W-1:0] rr_ptr;
  logic            found;
  int              idx;

  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = 0;
    for (int i = 0; i < N; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        found       = 1'b1;
        grant[idx]  = 1'b1;
        grant_id    = ID_W'(idx);
      end
    end
  end

  // N need not be a power of two, so the wrap is explicit.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (advance) begin
      rr_ptr <= (grant_id == ID_W'(N - 1)) ? '0 : grant_id + 1'b1;
    end
  end

endmodule

// File: rtl/mcash_xbar_arb.sv
// Serialises CH_NUM channel requests onto one registered downstream port.
// Optional perf counters are built when MCASH_XBAR_ARB_PERF_EN is defined.
module mcash_xbar_arb
  import mcash_xbar_pkg::*;
#(
  parameter int CH_NUM = MCASH_CH_NUM,
  parameter int ADDR_W = MCASH_ADDR_W,
  parameter int DATA_W = MCASH_DATA_W,
  parameter int OP_W   = MCASH_OP_W,
  localparam int ID_W  = $clog2(CH_NUM)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [CH_NUM-1:0]        ch_req_valid_i,
  output logic [CH_NUM-1:0]        ch_req_allowIn_o,
  input  logic [CH_NUM*OP_W-1:0]   ch_req_op_i,
  input  logic [CH_NUM*ADDR_W-1:0] ch_req_addr_i,
  input  logic [CH_NUM*DATA_W-1:0] ch_req_data_i,
  output logic                     xbar_req_valid_o,
  input  logic                     xbar_req_allowIn_i,
  output logic [OP_W-1:0]          xbar_req_op_o,
  output logic [ADDR_W-1:0]        xbar_req_addr_o,
  output logic [DATA_W-1:0]        xbar_req_data_o,
  output logic [ID_W-1:0]          xbar_req_ch_o
`ifdef MCASH_XBAR_ARB_PERF_EN
  ,
  output logic [CH_NUM*32-1:0]     perf_grant_cnt_o,
  output logic [31:0]              perf_stall_cnt_o
`endif
);

  function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] r;
    r = a;
    r[LINE_OFF_W-1:0] = '0;
    return r;
  endfunction

  logic              ld;
  logic              xfer;
  logic [CH_NUM-1:0] grant;
  logic [ID_W-1:0]   grant_id;

  logic [OP_W-1:0]   sel_op_p0;
  logic [ADDR_W-1:0] sel_addr_p0;
  logic [DATA_W-1:0] sel_data_p0;

  logic              vld_p1;
  logic [OP_W-1:0]   op_p1;
  logic [ADDR_W-1:0] addr_p1;
  logic [DATA_W-1:0] data_p1;
  logic [ID_W-1:0]   ch_p1;

  // The output register may load whenever it is empty or being drained.
  assign ld               = ~vld_p1 | xbar_req_allowIn_i;
  assign ch_req_allowIn_o = grant & {CH_NUM{ld & ~rst}};
  assign xfer             = |ch_req_allowIn_o;

  mcash_rr_arbiter #(
    .N (CH_NUM)
  ) u_rr (
    .clk      (clk),
    .rst      (rst),
    .req      (ch_req_valid_i),
    .advance  (xfer),
    .grant    (grant),
    .grant_id (grant_id)
  );

  // ---- stage p0: select the granted channel's payload ----
  assign sel_op_p0   = ch_req_op_i[int'(grant_id)*OP_W +: OP_W];
  assign sel_addr_p0 = line_align(ch_req_addr_i[int'(grant_id)*ADDR_W +: ADDR_W]);
  assign sel_data_p0 = ch_req_data_i[int'(grant_id)*DATA_W +: DATA_W];

  // ---- stage p1: output register; payload is also cleared so reset outputs read zero ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      op_p1   <= '0;
      addr_p1 <= '0;
      data_p1 <= '0;
      ch_p1   <= '0;
    end else if (ld) begin
      vld_p1 <= xfer;
      if (xfer) begin
        op_p1   <= sel_op_p0;
        addr_p1 <= sel_addr_p0;
        data_p1 <= sel_data_p0;
        ch_p1   <= grant_id;
      end
    end
  end

  assign xbar_req_valid_o = vld_p1;
  assign xbar_req_op_o    = op_p1;
  assign xbar_req_addr_o  = addr_p1;
  assign xbar_req_data_o  = data_p1;
  assign xbar_req_ch_o    = ch_p1;

`ifdef MCASH_XBAR_ARB_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] c);
    return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
  endfunction

  logic [31:0] grant_cnt [CH_NUM];
  logic [31:0] stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CH_NUM; i++) grant_cnt[i] <= '0;
      stall_cnt <= '0;
    end else begin
      for (int i = 0; i < CH_NUM; i++) begin
        if (ch_req_valid_i[i] & ch_req_allowIn_o[i]) grant_cnt[i] <= sat_inc(grant_cnt[i]);
      end
      if (vld_p1 & ~xbar_req_allowIn_i) stall_cnt <= sat_inc(stall_cnt);
    end
  end

  for (genvar g = 0; g < CH_NUM; g++) begin : g_perf
    assign perf_grant_cnt_o[g*32 +: 32] = grant_cnt[g];
  end
  assign perf_stall_cnt_o = stall_cnt;
`endif

endmodule

// File: tb/tb_mcash_xbar_arb.sv
// Self-checking bench for mcash_xbar_arb: directed scenarios plus random traffic
// compared against a cycle-level behavioural model of the round-robin rules.
module tb_mcash_xbar_arb;

  localparam int N = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    ch_valid;
  logic [N-1:0]    ch_allow;
  logic [N*3-1:0]  ch_op;
  logic [N*32-1:0] ch_addr;
  logic [N*64-1:0] ch_data;
  logic            x_valid;
  logic            x_allow;
  logic [2:0]      x_op;
  logic [31:0]     x_addr;
  logic [63:0]     x_data;
  logic [1:0]      x_ch;
`ifdef MCASH_XBAR_ARB_PERF_EN
  logic [N*32-1:0] perf_grant;
  logic [31:0]     perf_stall;
`endif

  always #5 clk = ~clk;

  mcash_xbar_arb dut (
    .clk                (clk),
    .rst                (rst),
    .ch_req_valid_i     (ch_valid),
    .ch_req_allowIn_o   (ch_allow),
    .ch_req_op_i        (ch_op),
    .ch_req_addr_i      (ch_addr),
    .ch_req_data_i      (ch_data),
    .xbar_req_valid_o   (x_valid),
    .xbar_req_allowIn_i (x_allow),
    .xbar_req_op_o      (x_op),
    .xbar_req_addr_o    (x_addr),
    .xbar_req_data_o    (x_data),
    .xbar_req_ch_o      (x_ch)
`ifdef MCASH_XBAR_ARB_PERF_EN
    ,
    .perf_grant_cnt_o   (perf_grant),
    .perf_stall_cnt_o   (perf_stall)
`endif
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model state: what the output port should show, and the rr pointer.
  bit          mv;
  logic [2:0]  mop;
  logic [31:0] maddr;
  logic [63:0] mdata;
  int          mch;
  int          mptr;
  int          acc;
  logic [N-1:0] obs_allow;

  task automatic model_clear();
    mv = 0; mop = '0; maddr = '0; mdata = '0; mch = 0; mptr = 0;
  endtask

  // Inputs are set at a negedge; this checks allowIn mid-cycle, advances the
  // model across the posedge and checks the outputs at the following negedge.
  task automatic step();
    int g;
    bit ld;
    #1;
    ld = !mv || x_allow;
    g = -1;
    if (!rst && ld) begin
      for (int i = 0; i < N; i++) begin
        int c;
        c = (mptr + i) % N;
        if (ch_valid[c] && g < 0) g = c;
      end
    end
    obs_allow = ch_allow;
    chk("allowIn", 64'(ch_allow), (g < 0) ? 64'd0 : (64'd1 << g));
    acc = g;
    @(posedge clk);
    if (rst) begin
      model_clear();
    end else if (ld) begin
      if (g >= 0) begin
        mv    = 1;
        mop   = ch_op[g*3 +: 3];
        maddr = {ch_addr[g*32+4 +: 28], 4'b0000};
        mdata = ch_data[g*64 +: 64];
        mch   = g;
        mptr  = (g + 1) % N;
      end else begin
        mv = 0;
      end
    end
    @(negedge clk);
    chk("out_valid", 64'(x_valid), 64'(mv));
    chk("out_op", 64'(x_op), 64'(mop));
    chk("out_addr", 64'(x_addr), 64'(maddr));
    chk("out_data", x_data, mdata);
    chk("out_ch", 64'(x_ch), 64'(mch));
  endtask

  task automatic set_req(input int c, input logic [2:0] o, input logic [31:0] a, input logic [63:0] d);
    ch_valid[c]       = 1'b1;
    ch_op[c*3 +: 3]   = o;
    ch_addr[c*32 +: 32] = a;
    ch_data[c*64 +: 64] = d;
  endtask

  task automatic set_rand(input int c);
    set_req(c, 3'($urandom), $urandom, {$urandom, $urandom});
  endtask

  task automatic do_reset();
    rst = 1; ch_valid = '0; x_allow = 1'b1;
    step();
    rst = 0;
  endtask

  initial begin
    rst = 1; ch_valid = '0; x_allow = 1'b0;
    ch_op = '0; ch_addr = '0; ch_data = '0;
    model_clear();
    @(negedge clk);

    // Reset state and a single request from ch2.
    do_reset();
    chk("rst_valid", 64'(x_valid), 64'd0);
    set_req(2, 3'd1, 32'h0000_1234, 64'hA5);
    step();
    chk("single_allow", 64'(obs_allow), 64'h4);
    chk("single_addr", 64'(x_addr), 64'h1230);
    chk("single_ch", 64'(x_ch), 64'd2);
    ch_valid = '0;
    step();

    // All channels continuously valid: strict 0,1,2,3 rotation, no bubbles.
    do_reset();
    for (int c = 0; c < N; c++) set_rand(c);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("rr_seq", 64'(x_ch), 64'(i % N));
      chk("rr_valid", 64'(x_valid), 64'd1);
      if (acc >= 0) set_rand(acc);
    end

    // Backpressure while ch1 is held on the output.
    do_reset();
    set_rand(1);
    step();
    ch_valid = '0;
    set_rand(0); set_rand(3);
    x_allow = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_allow", 64'(obs_allow), 64'd0);
      chk("bp_ch", 64'(x_ch), 64'd1);
    end
    x_allow = 1'b1;
    step();
    chk("bp_next", 64'(obs_allow), 64'h8);

    // Accept and refill in the same cycle.
    do_reset();
    set_rand(0); set_rand(1);
    step();
    chk("refill_ch0", 64'(x_ch), 64'd0);
    ch_valid[0] = 1'b0;
    step();
    chk("refill_ch1", 64'(x_ch), 64'd1);
    chk("refill_valid", 64'(x_valid), 64'd1);

    // Reset while the output holds ch2; afterwards ch0 wins over ch3.
    do_reset();
    set_rand(2);
    step();
    ch_valid = '0;
    x_allow = 1'b0;
    rst = 1;
    step();
    chk("rst_mid_valid", 64'(x_valid), 64'd0);
    chk("rst_mid_data", x_data, 64'd0);
    rst = 0;
    x_allow = 1'b1;
    set_rand(0); set_rand(3);
    step();
    chk("rst_first", 64'(obs_allow), 64'h1);

`ifdef MCASH_XBAR_ARB_PERF_EN
    do_reset();
    for (int i = 0; i < 10; i++) begin
      set_rand(1);
      step();
    end
    ch_valid = '0;
    x_allow = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("perf_grant1", 64'(perf_grant[32 +: 32]), 64'd10);
    chk("perf_stall", 64'(perf_stall), 64'd3);
    x_allow = 1'b1;
`endif

    // Random traffic against the model.
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int c = 0; c < N; c++) begin
        if (!ch_valid[c] && ($urandom_range(1, 0) == 1)) set_rand(c);
      end
      x_allow = ($urandom_range(3, 0) != 0);
      rst = ($urandom_range(63, 0) == 0);
      step();
      if (acc >= 0) ch_valid[acc] = 1'b0;
    end
    rst = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mcash_xbar_arb.md
# mcash_xbar_arb

Round-robin request arbiter for the mcash cross bar. It collects the per-channel cache requests (valid/allowIn handshake, op/addr/data) from `CH_NUM` requesters and serialises them onto the single downstream request port of the cross bar datapath. Each forwarded request is tagged with its source channel id. The output is registered, so downstream timing is isolated from the requesters.

## Interface
Parameters:
- `CH_NUM`, 4, number of requesting channels (2..8)
- `ADDR_W`, 32, request address width
- `DATA_W`, 64, request data width
- `OP_W`, 3, request opcode width

Ports:
- `clk` input 1: single clock; all logic on posedge
- `rst` input 1: reset, synchronous, active-high
- `ch_req_valid_i` input CH_NUM: per-channel request valid
- `ch_req_allowIn_o` output CH_NUM: per-channel accept; a transfer occurs when valid & allowIn
- `ch_req_op_i` input CH_NUM*OP_W: packed opcodes, channel i at [i*OP_W +: OP_W]
- `ch_req_addr_i` input CH_NUM*ADDR_W: packed addresses
- `ch_req_data_i` input CH_NUM*DATA_W: packed data
- `xbar_req_valid_o` output 1: downstream request valid
- `xbar_req_allowIn_i` input 1: downstream accept
- `xbar_req_op_o` output OP_W: forwarded opcode
- `xbar_req_addr_o` output ADDR_W: forwarded address, line aligned ([3:0] forced to 0)
- `xbar_req_data_o` output DATA_W: forwarded data
- `xbar_req_ch_o` output $clog2(CH_NUM): source channel id

## Operation
- One output register (`out_valid` plus payload). Its load enable is `ld = ~out_valid | xbar_req_allowIn_i`.
- Grant is combinational and one-hot among `ch_req_valid_i`. Search starts at pointer `rr_ptr` and wraps upward. At most one channel is granted per cycle.
- `ch_req_allowIn_o[i] = grant[i] & ld & ~rst`. Non-granted channels see 0.
- On transfer from channel k:
  - payload loads op, {addr[ADDR_W-1:4], 4'b0}, data, ch id k
  - `out_valid` is set to 1
  - `rr_ptr` becomes (k+1) mod CH_NUM
- If `ld` is true and no channel is valid, `out_valid` is cleared to 0. The payload holds its last value.
- If `out_valid & ~xbar_req_allowIn_i`, the register and `rr_ptr` hold and all allowIn outputs are 0.
- A downstream accept and a new upstream transfer in the same cycle give back-to-back output with no bubble.
- Requesters must hold valid and payload stable until accepted. The arbiter does not check this.
- `rr_ptr` does not move in cycles with no transfer.

## Timing
- Latency: transfer in cycle t puts the request on `xbar_req_*` in cycle t+1.
- Throughput: 1 request/cycle while `xbar_req_allowIn_i` is held high.
- Fairness: a continuously valid channel is granted within CH_NUM transfers.
- Reset values, applied in the cycle after `rst` is sampled high:
  - `xbar_req_valid_o`=0
  - op/addr/data/ch outputs = 0
  - `rr_ptr`=0
- `ch_req_allowIn_o`=0 combinationally while `rst`=1.
- Reset asserted while `out_valid`=1 drops the held request without handshake.

## Configuration
- `MCASH_XBAR_ARB_PERF_EN` defined:
  - Adds output `perf_grant_cnt_o` (CH_NUM*32): per-channel count of transfers.
  - Adds output `perf_stall_cnt_o` (32): count of cycles with `out_valid & ~xbar_req_allowIn_i`.
  - All counters are saturating at 32'hFFFF_FFFF and reset to 0.
- Macro not defined: these ports and counters are absent. Arbitration behaviour is identical in both builds.

## Structure
- Package `mcash_xbar_pkg` holds:
  - defaults `MCASH_CH_NUM`, `MCASH_ADDR_W`, `MCASH_DATA_W`, `MCASH_OP_W`
  - `mcash_req_t` struct (op, addr, data)
  - `ch_id_t` typedef
  - `LINE_OFF_W`=4
- Sub-module `mcash_rr_arbiter` (params N) contains the `rr_ptr` register and the one-hot grant/encode. Its interface:
  - inputs: `req[N]`, `advance`
  - outputs: `grant[N]`, `grant_id`
- The top level holds the output register, the payload mux and the optional perf counters.

## Test plan
- Single request: ch2 valid, op=3'd1, addr=32'h0000_1234, data=64'hA5, downstream ready → allowIn[2]=1 in the same cycle; next cycle `xbar_req_valid_o`=1, addr=32'h0000_1230, ch=2.
- All 4 channels valid continuously, downstream ready → output ch sequence 0,1,2,3,0,… with one request per cycle and no bubbles.
- Backpressure: output valid with ch1 held, `xbar_req_allowIn_i`=0 for 5 cycles while ch0/ch3 are valid → all allowIn=0 and output stable for 5 cycles; after release, ch3 is accepted next (`rr_ptr`=2 wraps to 3).
- Accept and refill together: ch0 then ch1 requests with downstream always ready → ch0 on output in cycle t+1, ch1 in cycle t+2, valid never drops.
- Reset mid-operation: `rst`=1 while output valid holds ch2 → next cycle valid=0 and outputs zero; after reset, ch0 and ch3 valid → ch0 granted first.
- PERF_EN build: 10 transfers from ch1 and 3 stall cycles → `perf_grant_cnt_o[1]`=10, `perf_stall_cnt_o`=3; a forced count at 32'hFFFF_FFFF stays saturated after a further transfer.
